// File: rtl/cruise_button_conditioner.sv
// Cruise-control stalk/pedal conditioner: 2-flop sync, per-input debounce, edge-to-pulse,
// priority arbitration and brake/conflict gating. Define CRUISE_AUTOREPEAT_EN for accel/coast auto-repeat.
module cruise_button_conditioner #(
  parameter int unsigned DB_CYCLES    = 4,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_set,
  input  logic raw_accel,
  input  logic raw_coast,
  input  logic raw_cancel,
  input  logic raw_resume,
  input  logic raw_brake,
  input  logic raw_throttle,
  output logic set,
  output logic accel,
  output logic coast,
  output logic cancel,
  output logic resume,
  output logic brake,
  output logic throttle,
  output logic conflict
);

  // Bit positions shared by the raw, debounced and command vectors.
  localparam int I_SET      = 0;
  localparam int I_ACCEL    = 1;
  localparam int I_COAST    = 2;
  localparam int I_CANCEL   = 3;
  localparam int I_RESUME   = 4;
  localparam int I_BRAKE    = 5;
  localparam int I_THROTTLE = 6;
  localparam int N_IN       = 7;
  localparam int N_CMD      = 5;

  if (DB_CYCLES < 2 || DB_CYCLES > 255 || REPEAT_DELAY < 2 || REPEAT_DELAY > 1023 ||
      REPEAT_RATE < 2 || REPEAT_RATE > 1023) begin : g_param_check
    $error("cruise_button_conditioner: parameter out of range");
  end

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic [N_IN-1:0]  raw_w;
  logic [N_IN-1:0]  sync1_q, sync2_q, db_q;
  logic [7:0]       db_cnt_q [N_IN];
  logic [N_CMD-1:0] db_prev_q, rise_q;
  logic [N_CMD-1:0] cand_w, grant_w, cmd_q;
  logic [1:0]       rep_fire_w;
  logic             brake_q, throttle_q, conflict_q;
  logic             brake_db_w, conflict_db_w;

  assign raw_w = {raw_throttle, raw_brake, raw_resume, raw_cancel, raw_coast, raw_accel, raw_set};
  assign brake_db_w    = db_q[I_BRAKE];
  assign conflict_db_w = db_q[I_ACCEL] & db_q[I_COAST];

  // Synchronize and debounce every input; a debounced level only flips after DB_CYCLES
  // consecutive disagreeing samples, any agreeing sample restarts the count.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      rise_q    <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
      for (int i = 0; i < N_IN; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw_w;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q[N_CMD-1:0];
      rise_q    <= db_q[N_CMD-1:0] & ~db_prev_q;
      for (int i = 0; i < N_IN; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= ~db_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Gate candidates by brake/conflict, then keep only the highest-priority one.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cand_w           = '0;
    cand_w[I_CANCEL] = rise_q[I_CANCEL];
    cand_w[I_SET]    = rise_q[I_SET]    & ~brake_db_w;
    cand_w[I_RESUME] = rise_q[I_RESUME] & ~brake_db_w;
    cand_w[I_ACCEL]  = (rise_q[I_ACCEL] | rep_fire_w[0]) & ~brake_db_w & ~conflict_db_w;
    cand_w[I_COAST]  = (rise_q[I_COAST] | rep_fire_w[1]) & ~brake_db_w & ~conflict_db_w;

    grant_w = '0;
    if      (cand_w[I_CANCEL]) grant_w[I_CANCEL] = 1'b1;
    else if (cand_w[I_SET])    grant_w[I_SET]    = 1'b1;
    else if (cand_w[I_RESUME]) grant_w[I_RESUME] = 1'b1;
    else if (cand_w[I_ACCEL])  grant_w[I_ACCEL]  = 1'b1;
    else if (cand_w[I_COAST])  grant_w[I_COAST]  = 1'b1;
  end

`ifdef CRUISE_AUTOREPEAT_EN
  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_e;

  localparam logic [9:0] RPT_DELAY_N = 10'(REPEAT_DELAY);
  localparam logic [9:0] RPT_RATE_N  = 10'(REPEAT_RATE);

  rpt_state_e rpt_state_q [2];
  logic [9:0] rpt_cnt_q   [2];
  logic [1:0] rpt_abort_w;

  // Slot 0 repeats accel, slot 1 repeats coast; the count is cycles since the last pulse slot.
  always_comb begin
    rpt_abort_w = '0;
    rep_fire_w  = '0;
    for (int r = 0; r < 2; r++) begin
      rpt_abort_w[r] = ~db_q[I_ACCEL + r] | brake_db_w | conflict_db_w;
      rep_fire_w[r]  = ~rpt_abort_w[r] &
                       ((rpt_state_q[r] == RPT_DELAY  && rpt_cnt_q[r] == RPT_DELAY_N) ||
                        (rpt_state_q[r] == RPT_REPEAT && rpt_cnt_q[r] == RPT_RATE_N));
    end
  end

  // A repeat slot restarts the interval even when arbitration drops its pulse, so timing never slips.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 2; r++) begin
        rpt_state_q[r] <= RPT_IDLE;
        rpt_cnt_q[r]   <= '0;
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (rpt_abort_w[r]) begin
          rpt_state_q[r] <= RPT_IDLE;
          rpt_cnt_q[r]   <= '0;
        end else begin
          case (rpt_state_q[r])
            RPT_IDLE: begin
              if (grant_w[I_ACCEL + r]) begin
                rpt_state_q[r] <= RPT_DELAY;
                rpt_cnt_q[r]   <= 10'd1;
              end
            end
            RPT_DELAY: begin
              if (rep_fire_w[r]) begin
                rpt_state_q[r] <= RPT_REPEAT;
                rpt_cnt_q[r]   <= 10'd1;
              end else if (rpt_cnt_q[r] != 10'h3FF) begin
                rpt_cnt_q[r] <= rpt_cnt_q[r] + 10'd1;
              end
            end
            RPT_REPEAT: begin
              if (rep_fire_w[r]) begin
                rpt_cnt_q[r] <= 10'd1;
              end else if (rpt_cnt_q[r] != 10'h3FF) begin
                rpt_cnt_q[r] <= rpt_cnt_q[r] + 10'd1;
              end
            end
            default: begin
              rpt_state_q[r] <= RPT_IDLE;
              rpt_cnt_q[r]   <= '0;
            end
          endcase
        end
      end
    end
  end
`else
  assign rep_fire_w = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q      <= '0;
      brake_q    <= 1'b0;
      throttle_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      cmd_q      <= grant_w;
      brake_q    <= db_q[I_BRAKE];
      throttle_q <= db_q[I_THROTTLE];
      conflict_q <= conflict_db_w;
    end
  end

  assign set      = cmd_q[I_SET];
  assign accel    = cmd_q[I_ACCEL];
  assign coast    = cmd_q[I_COAST];
  assign cancel   = cmd_q[I_CANCEL];
  assign resume   = cmd_q[I_RESUME];
  assign brake    = brake_q;
  assign throttle = throttle_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_cruise_button_conditioner.sv
// Scoreboard bench for cruise_button_conditioner (defaults DB=4, delay=16, rate=4);
// expectations follow CRUISE_AUTOREPEAT_EN when it is defined for the build.
module tb_cruise_button_conditioner;

  localparam logic [4:0] C_SET    = 5'b00001;
  localparam logic [4:0] C_ACCEL  = 5'b00010;
  localparam logic [4:0] C_COAST  = 5'b00100;
  localparam logic [4:0] C_CANCEL = 5'b01000;
  localparam logic [4:0] C_RESUME = 5'b10000;

  typedef struct {
    int         edge_n;
    logic [4:0] cmd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic raw_set = 0, raw_accel = 0, raw_coast = 0, raw_cancel = 0, raw_resume = 0;
  logic raw_brake = 0, raw_throttle = 0;
  logic set, accel, coast, cancel, resume, brake, throttle, conflict;
  logic [4:0] pulses;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;

  cruise_button_conditioner dut (
    .clk          (clk),
    .reset        (reset),
    .raw_set      (raw_set),
    .raw_accel    (raw_accel),
    .raw_coast    (raw_coast),
    .raw_cancel   (raw_cancel),
    .raw_resume   (raw_resume),
    .raw_brake    (raw_brake),
    .raw_throttle (raw_throttle),
    .set          (set),
    .accel        (accel),
    .coast        (coast),
    .cancel       (cancel),
    .resume       (resume),
    .brake        (brake),
    .throttle     (throttle),
    .conflict     (conflict)
  );

  assign pulses = {resume, cancel, coast, accel, set};

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic push(input int e, input logic [4:0] c);
    exp_t x;
    x.edge_n = e;
    x.cmd    = c;
    sb.push_back(x);
  endtask

  // Returns at the falling edge that follows rising edge number e.
  task automatic at_edge(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  // Monitor: any command pulse must match the oldest expected event in edge and identity.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pulses != 5'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", int'(pulses), 0);
        end else begin
          e = sb.pop_front();
          check("pulse_edge", edge_cnt, e.edge_n);
          check("pulse_cmd", int'(pulses), int'(e.cmd));
        end
      end
    end
  end

  initial begin
    int k, m;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({pulses, brake, throttle, conflict}), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Held set: single pulse seven edges after the first sampling edge.
    k = edge_cnt;
    raw_set = 1'b1;
    push(k + 8, C_SET);
    at_edge(k + 20);
    raw_set = 1'b0;
    at_edge(k + 32);
    check("sb_empty_set", sb.size(), 0);

    // Three-sample glitch is rejected; four stable samples give one pulse.
    k = edge_cnt;
    raw_accel = 1'b1;
    at_edge(k + 3);
    raw_accel = 1'b0;
    at_edge(k + 12);
    k = edge_cnt;
    raw_accel = 1'b1;
    push(k + 8, C_ACCEL);
    at_edge(k + 4);
    raw_accel = 1'b0;
    at_edge(k + 30);
    check("sb_empty_glitch", sb.size(), 0);

    // Long accel hold: initial pulse, then auto-repeat when enabled.
    k = edge_cnt;
    raw_accel = 1'b1;
    push(k + 8, C_ACCEL);
`ifdef CRUISE_AUTOREPEAT_EN
    for (int p = 24; p <= 44; p += 4) push(k + p, C_ACCEL);
`endif
    at_edge(k + 40);
    raw_accel = 1'b0;
    at_edge(k + 70);
    check("sb_empty_repeat", sb.size(), 0);

    // Priority: cancel beats set, set beats resume.
    k = edge_cnt;
    raw_cancel = 1'b1;
    raw_set    = 1'b1;
    push(k + 8, C_CANCEL);
    at_edge(k + 12);
    raw_cancel = 1'b0;
    raw_set    = 1'b0;
    at_edge(k + 24);
    k = edge_cnt;
    raw_set    = 1'b1;
    raw_resume = 1'b1;
    push(k + 8, C_SET);
    at_edge(k + 12);
    raw_set    = 1'b0;
    raw_resume = 1'b0;
    at_edge(k + 24);
    check("sb_empty_prio", sb.size(), 0);

    // Pedal levels and brake gating: resume suppressed, cancel passes, no pulse after brake clears.
    k = edge_cnt;
    raw_brake    = 1'b1;
    raw_throttle = 1'b1;
    at_edge(k + 6);
    check("brake_before", int'(brake), 0);
    check("throttle_before", int'(throttle), 0);
    at_edge(k + 7);
    check("brake_after", int'(brake), 1);
    check("throttle_after", int'(throttle), 1);
    raw_throttle = 1'b0;
    at_edge(k + 10);
    raw_resume = 1'b1;
    at_edge(k + 20);
    raw_cancel = 1'b1;
    push(k + 28, C_CANCEL);
    at_edge(k + 24);
    raw_cancel = 1'b0;
    at_edge(k + 35);
    raw_brake = 1'b0;
    at_edge(k + 60);
    check("brake_released", int'(brake), 0);
    check("throttle_released", int'(throttle), 0);
    raw_resume = 1'b0;
    at_edge(k + 75);
    check("sb_empty_brake", sb.size(), 0);

    // Accel and coast together: conflict level, no pulses at all.
    k = edge_cnt;
    raw_accel = 1'b1;
    raw_coast = 1'b1;
    at_edge(k + 6);
    check("conflict_before", int'(conflict), 0);
    at_edge(k + 7);
    check("conflict_after", int'(conflict), 1);
    at_edge(k + 40);
    check("conflict_held", int'(conflict), 1);
    raw_accel = 1'b0;
    raw_coast = 1'b0;
    at_edge(k + 55);
    check("conflict_released", int'(conflict), 0);

    // Coast pressed while accel held: accel pulses once, coast and repeats suppressed.
    k = edge_cnt;
    raw_accel = 1'b1;
    push(k + 8, C_ACCEL);
    at_edge(k + 3);
    raw_coast = 1'b1;
    at_edge(k + 10);
    check("conflict_stagger", int'(conflict), 1);
    at_edge(k + 40);
    raw_accel = 1'b0;
    raw_coast = 1'b0;
    at_edge(k + 55);
    check("sb_empty_conflict", sb.size(), 0);

    // Reset mid-repeat clears outputs at once; held button counts as a fresh press after release.
    k = edge_cnt;
    raw_accel = 1'b1;
    push(k + 8, C_ACCEL);
`ifdef CRUISE_AUTOREPEAT_EN
    push(k + 24, C_ACCEL);
`endif
    at_edge(k + 24);
    #2 reset = 1'b0;
    #1 check("reset_async", int'({pulses, brake, throttle, conflict}), 0);
    repeat (3) @(negedge clk);
    check("reset_hold", int'({pulses, brake, throttle, conflict}), 0);
    m = edge_cnt;
    reset = 1'b1;
    push(m + 8, C_ACCEL);
`ifdef CRUISE_AUTOREPEAT_EN
    push(m + 24, C_ACCEL);
`endif
    at_edge(m + 20);
    raw_accel = 1'b0;
    at_edge(m + 40);
    check("sb_empty_reset", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cruise_button_conditioner.md
CRUISE_BUTTON_CONDITIONER -- requirements
Module: cruise_button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, 4, consecutive stable synchronized samples required to change a debounced level (range 2..255).
REQ-002 Parameter REPEAT_DELAY, 16, cycles from initial accel/coast pulse to first auto-repeat pulse (range 2..1023).
REQ-003 Parameter REPEAT_RATE, 4, cycles between successive auto-repeat pulses (range 2..1023).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 raw_set, raw_accel, raw_coast, raw_cancel, raw_resume  input  1 each  unsynchronized, bouncy driver push-buttons.
REQ-007 raw_brake, raw_throttle  input  1 each  unsynchronized pedal switches.
REQ-008 set, accel, coast, cancel, resume  output  1 each  registered single-cycle command pulses for the cruise controller.
REQ-009 brake, throttle  output  1 each  registered debounced pedal levels.
REQ-010 conflict  output  1  registered; high while debounced accel and coast are both high.

Function
REQ-011 Each raw input SHALL pass a 2-flop synchronizer, then a per-input debounce counter.
REQ-012 Debounced level SHALL toggle only after DB_CYCLES consecutive synchronized samples differ from it; any matching sample clears the counter.
REQ-013 brake/throttle SHALL equal their debounced levels; latency raw edge to output = DB_CYCLES+2 edges.
REQ-014 A rising edge of a debounced button level SHALL produce a one-cycle pulse on its output; latency raw edge to pulse = DB_CYCLES+3 edges; falling edges produce nothing.
REQ-015 At most one command pulse per cycle; simultaneous candidates resolve cancel > set > resume > accel > coast; losers are dropped, not queued.
REQ-016 While debounced brake is high, set/resume/accel/coast pulses SHALL be suppressed; cancel SHALL still pass.
REQ-017 While conflict is high, accel and coast pulses (initial and repeat) SHALL be suppressed.
REQ-018 A button already debounced high when brake or conflict clears SHALL NOT pulse; a new press is required.
REQ-019 Per-button repeat FSM (accel, coast): IDLE -> DELAY on emitted initial pulse; DELAY -> REPEAT after REPEAT_DELAY cycles, emitting a pulse; REPEAT emits a pulse every REPEAT_RATE cycles; any state -> IDLE on debounced release, brake high, or conflict high.
REQ-020 Repeat pulses losing priority arbitration SHALL be dropped; repeat timing SHALL NOT slip.
REQ-021 Repeat counters SHALL saturate, never wrap; width sized to parameter maximum.
REQ-022 A button held high across reset release SHALL pulse once after DB_CYCLES+3 edges (treated as a press).

Reset
REQ-023 reset low SHALL immediately force all outputs to 0, synchronizers/debounced levels/counters to 0, and FSMs to IDLE.
REQ-024 Reset asserted mid-debounce or mid-repeat SHALL discard all progress; no pulse emitted for that press after release unless REQ-022 applies.

Configuration
REQ-025 Macro CRUISE_AUTOREPEAT_EN: defined -> REQ-019..REQ-021 active; undefined -> repeat FSMs and counters absent, accel/coast emit exactly one pulse per press, all other behaviour identical.

Verification (DB_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=4)
REQ-026 raw_set high at edge 0, held -> set high for exactly one cycle after edge 7; no further pulse.
REQ-027 raw_accel glitch high 3 cycles then low -> no accel pulse; 4-cycle stable press -> one pulse.
REQ-028 raw_accel held 40 cycles, macro defined -> pulses at P, P+16, P+20, P+24, ...; macro undefined -> pulse at P only.
REQ-029 raw_cancel and raw_set rise same edge -> only cancel pulses; raw_brake high then raw_resume pressed -> no resume pulse, brake high after edge 6.
REQ-030 raw_accel and raw_coast both held -> conflict high, no accel/coast pulses; reset pulsed low mid-repeat -> all outputs 0 same cycle, FSM IDLE.
